// File: rtl/axi_sram_slave_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_sram_slave_pkg : response codes, FSM states, latency counter width   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package axi_sram_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_sram_slave_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_sram_slave_if : AXI-lite style read/write channels with modports     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface axi_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface
`default_nettype wire

// File: rtl/axi_sram_lat_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_sram_lat_cnt : per-channel latency countdown; AXI_SRAM_RAND_LAT_EN   |
// | adds a 4-bit LFSR jitter to the load value. Revision 1.0                 |
// +--------------------------------------------------------------------------+
module axi_sram_lat_cnt
  import axi_sram_slave_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam logic [LAT_CNT_W-1:0] LAT_V = LAT_CNT_W'(LAT);

  logic [LAT_CNT_W-1:0] cnt_q;
  logic [LAT_CNT_W-1:0] load_d;

`ifdef AXI_SRAM_RAND_LAT_EN
  logic [3:0] lfsr_q;

  // x^4 + x^3 + 1, free-running from reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr_q <= 4'b0001;
    else       lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end

  assign load_d = lfsr_q % LAT_V;
`else
  assign load_d = LAT_V - 1'b1;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                    cnt_q <= '0;
    else if (load_i)              cnt_q <= load_d;
    else if (dec_i && cnt_q != 0) cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_sram_slave : single-outstanding AXI-lite SRAM with independent R/W   |
// | FSMs; AXI_SRAM_RAND_LAT_EN randomises latency. Revision 1.0              |
// +--------------------------------------------------------------------------+
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    RD_LAT     = 1,
  parameter int                    WR_LAT     = 1
) (
  input  logic             clk,
  input  logic             rstn,
  axi_sram_slave_if.slave  bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_WORDS * 4);

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // ---------------- read channel ----------------
  rd_state_t             rd_state_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [ADDR_WIDTH-1:0] rd_off;
  logic                  rd_in_range;
  logic                  rd_zero;

  assign rd_off      = araddr_q - BASE_ADDR;
  assign rd_in_range = {1'b0, rd_off} < MEM_BYTES;

  axi_sram_lat_cnt #(.LAT(RD_LAT)) u_rd_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (rd_state_q == R_IDLE && bus.arvalid),
    .dec_i  (rd_state_q == R_WAIT),
    .zero_o (rd_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      araddr_q   <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: if (bus.arvalid) begin
          araddr_q   <= bus.araddr;
          arready_q  <= 1'b0;
          rd_state_q <= R_WAIT;
        end
        // Sampled before any same-edge write commit lands: old data wins.
        R_WAIT: if (rd_zero) begin
          rdata_q    <= rd_in_range ? mem_q[rd_off[IDX_W+1:2]] : '0;
          rresp_q    <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
          rvalid_q   <= 1'b1;
          rd_state_q <= R_RESP;
        end
        R_RESP: if (bus.rready) begin
          rvalid_q   <= 1'b0;
          arready_q  <= 1'b1;
          rd_state_q <= R_IDLE;
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- write channel ----------------
  wr_state_t             wr_state_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic                  aw_held_q, w_held_q;
  logic [1:0]            bresp_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [ADDR_WIDTH-1:0] wr_off;
  logic                  wr_in_range, wr_zero;
  logic                  aw_fire, w_fire, aw_have_d, w_have_d;

  assign wr_off      = awaddr_q - BASE_ADDR;
  assign wr_in_range = {1'b0, wr_off} < MEM_BYTES;
  assign aw_fire     = bus.awvalid && awready_q;
  assign w_fire      = bus.wvalid && wready_q;
  assign aw_have_d   = aw_held_q || aw_fire;
  assign w_have_d    = w_held_q || w_fire;

  axi_sram_lat_cnt #(.LAT(WR_LAT)) u_wr_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (wr_state_q == W_IDLE && aw_have_d && w_have_d),
    .dec_i  (wr_state_q == W_WAIT),
    .zero_o (wr_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (aw_fire) awaddr_q <= bus.awaddr;
          if (w_fire) begin
            wdata_q <= bus.wdata;
            wstrb_q <= bus.wstrb;
          end
          awready_q <= !aw_have_d;
          wready_q  <= !w_have_d;
          if (aw_have_d && w_have_d) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            wr_state_q <= W_WAIT;
          end else begin
            aw_held_q <= aw_have_d;
            w_held_q  <= w_have_d;
          end
        end
        W_WAIT: if (wr_zero) begin
          bresp_q    <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
          bvalid_q   <= 1'b1;
          wr_state_q <= W_RESP;
        end
        W_RESP: if (bus.bready) begin
          bvalid_q   <= 1'b0;
          awready_q  <= 1'b1;
          wready_q   <= 1'b1;
          wr_state_q <= W_IDLE;
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_state_q == W_WAIT && wr_zero && wr_in_range) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb_q[i]) mem_q[wr_off[IDX_W+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi_sram_slave : directed vector table plus multi-cycle sequences     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_axi_sram_slave;

  localparam int BOUND = 50;

  logic clk;
  logic rstn;
  int   n_cmp  = 0;
  int   n_fail = 0;

  axi_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_sram_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_WORDS  (1024),
    .BASE_ADDR  (32'h8000_0000),
    .RD_LAT     (1),
    .WR_LAT     (1)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timeout after %0d cycles", name, BOUND);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rvalid(output int cyc);
    cyc = 0;
    while (!bus.rvalid && cyc < BOUND) begin tick(); cyc++; end
    if (!bus.rvalid) timeout("rvalid");
  endtask

  task automatic wait_bvalid(output int cyc);
    cyc = 0;
    while (!bus.bvalid && cyc < BOUND) begin tick(); cyc++; end
    if (!bus.bvalid) timeout("bvalid");
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    int n = 0;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    while (!bus.arready && n < BOUND) begin tick(); n++; end
    if (!bus.arready) timeout("arready");
    tick();
    bus.arvalid = 1'b0;
    wait_rvalid(lat);
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp, output int lat);
    int n = 0;
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    while (!(bus.awready && bus.wready) && n < BOUND) begin tick(); n++; end
    if (!(bus.awready && bus.wready)) timeout("aw/wready");
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    wait_bvalid(lat);
    resp = bus.bresp;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;

    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00, 32'h0};
    vecs[3]  = '{1'b1, 32'h8000_0024, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
    vecs[4]  = '{1'b1, 32'h8000_0026, 32'h5555_AAAA, 4'hC, 2'b00, 32'h0};
    vecs[5]  = '{1'b0, 32'h8000_0024, 32'h0,         4'h0, 2'b00, 32'h5555_F00D};
    vecs[6]  = '{1'b1, 32'h8000_0000, 32'h0123_4567, 4'hF, 2'b00, 32'h0};
    vecs[7]  = '{1'b0, 32'h8000_1000, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[8]  = '{1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0};
    vecs[9]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 2'b00, 32'h0123_4567};
    vecs[10] = '{1'b1, 32'h8000_0FFC, 32'hA5A5_A5A5, 4'hF, 2'b00, 32'h0};
    vecs[11] = '{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 2'b00, 32'hA5A5_A5A5};
    vecs[12] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[13] = '{1'b1, 32'h8000_0030, 32'h1111_1111, 4'hF, 2'b00, 32'h0};

    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_arready", 32'(bus.arready), 32'd1);
    check("rst_awready", 32'(bus.awready), 32'd1);
    check("rst_wready",  32'(bus.wready),  32'd1);
    check("rst_rvalid",  32'(bus.rvalid),  32'd0);
    check("rst_bvalid",  32'(bus.bvalid),  32'd0);
    check("rst_rdata",   bus.rdata,        32'd0);
    check("rst_rresp",   32'(bus.rresp),   32'd0);
    check("rst_bresp",   32'(bus.bresp),   32'd0);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r, lat);
        check($sformatf("v%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
        check($sformatf("v%0d_wlat", i), 32'(lat), 32'd1);
      end else begin
        do_read(vecs[i].addr, d, r, lat);
        check($sformatf("v%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
        check($sformatf("v%0d_rdata", i), d, vecs[i].exp_rdata);
        check($sformatf("v%0d_rlat", i), 32'(lat), 32'd1);
      end
    end

    // W beat two cycles ahead of AW, byte-0 merge over 0x11223344
    bus.wdata = 32'h0000_00AA; bus.wstrb = 4'b0001; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    check("wfirst_wready",  32'(bus.wready),  32'd0);
    check("wfirst_awready", 32'(bus.awready), 32'd1);
    tick();
    bus.awaddr = 32'h8000_0020; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    check("wfirst_bvalid_early", 32'(bus.bvalid), 32'd0);
    wait_bvalid(lat);
    check("wfirst_wlat", 32'(lat), 32'd1);
    check("wfirst_bresp", 32'(bus.bresp), 32'd0);
    bus.bready = 1'b1; tick(); bus.bready = 1'b0;
    do_read(32'h8000_0020, d, r, lat);
    check("wfirst_rdata", d, 32'h1122_33AA);

    // rready stall for 5 cycles in R_RESP
    bus.araddr = 32'h8000_0010; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    wait_rvalid(lat);
    for (int k = 0; k < 5; k++) begin
      check("stall_rvalid",  32'(bus.rvalid),  32'd1);
      check("stall_rdata",   bus.rdata,        32'hDEAD_BEEF);
      check("stall_arready", 32'(bus.arready), 32'd0);
      tick();
    end
    bus.rready = 1'b1; tick(); bus.rready = 1'b0;
    check("stall_rvalid_done", 32'(bus.rvalid),  32'd0);
    check("stall_arready_done", 32'(bus.arready), 32'd1);

    // reset pulse while the write sits in W_WAIT
    bus.awaddr = 32'h8000_0010; bus.wdata = 32'h0; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("rstw_awready_pre", 32'(bus.awready), 32'd0);
    rstn = 1'b0;
    #1;
    check("rstw_bvalid",  32'(bus.bvalid),  32'd0);
    check("rstw_awready", 32'(bus.awready), 32'd1);
    check("rstw_wready",  32'(bus.wready),  32'd1);
    #1;
    rstn = 1'b1;
    tick(); tick();
    check("rstw_bvalid_after", 32'(bus.bvalid), 32'd0);
    do_read(32'h8000_0010, d, r, lat);
    check("rstw_word_kept", d, 32'hDEAD_BEEF);

    // read sample and write commit on the same edge
    bus.araddr = 32'h8000_0030; bus.arvalid = 1'b1;
    bus.awaddr = 32'h8000_0030; bus.wdata = 32'h2222_2222; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    wait_rvalid(lat);
    check("same_edge_bvalid", 32'(bus.bvalid), 32'd1);
    check("same_edge_rdata", bus.rdata, 32'h1111_1111);
    check("same_edge_bresp", 32'(bus.bresp), 32'd0);
    bus.rready = 1'b1; bus.bready = 1'b1;
    tick();
    bus.rready = 1'b0; bus.bready = 1'b0;
    do_read(32'h8000_0030, d, r, lat);
    check("same_edge_new", d, 32'h2222_2222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
